ring_host_interface: RTL and testbench
======================================

Name: ring_host_interface

Overview:
- Network interface between a processing core and the host port of one ring router.
- Inject side: packetises core messages (destination + payload), buffers them in a FIFO, and injects them one per cycle-slot into the router.
- Eject side: captures packets the router delivers to its host, presents them to the core with a valid/ready handshake, and counts drops.
- Self-addressed packets loop back locally and never enter the ring.

Parameters:
- ROUTER_ID, 0, ID of the attached router; compared against the packet destination.
- PACKET_SIZE, 8, flit width; bits [ROUTER_BITS-1:0] are the destination, the rest is payload.
- ROUTER_BITS, 2, destination field width.
- FIFO_DEPTH, 4, injection FIFO entries (power of two, >=2).
- INJ_GAP, 1, idle cycles forced after each injection (0 allowed).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tx_valid  in  1  core offers a message
- tx_ready  out  1  FIFO can accept; combinational, equals FIFO not full
- tx_dest  in  ROUTER_BITS  destination router
- tx_payload  in  PACKET_SIZE-ROUTER_BITS  message payload
- inj_data  out  PACKET_SIZE  packet to router host_data_in
- inj_enable  out  1  one-cycle injection strobe to router host_enable_in
- net_busy  in  1  router input direction occupied (OR of neighbour enables); injection is held
- ej_valid  in  1  router delivering a packet to host this cycle
- ej_data  in  PACKET_SIZE  delivered packet
- rx_valid  out  1  eject slot holds a packet
- rx_data  out  PACKET_SIZE-ROUTER_BITS  payload of the slot packet
- rx_ready  in  1  core consumes slot
- inj_count  out  8  packets injected into the ring, wraps at 256
- drop_count  out  8  eject packets dropped, saturates at 255

Behaviour:
Reset:
- FIFO emptied; state IDLE; gap counter 0.
- inj_data=0, inj_enable=0, rx_valid=0, rx_data=0, inj_count=0, drop_count=0.
- Reset mid-operation discards all queued and slot packets.

Packet build and push:
- Packet = {tx_payload, tx_dest}.
- Push when tx_valid && tx_ready at the clock edge.
- Push and pop in the same cycle are both allowed when the FIFO is not full.
- When the FIFO is full, tx_ready=0 and there is no push.

Injector FSM (all outputs registered):
- IDLE, head dest == ROUTER_ID (loopback): if the eject slot is free or draining this edge, and ej_valid=0, load the slot with the head and pop. Otherwise hold. Stay in IDLE. inj_count is unchanged.
- IDLE, head dest != ROUTER_ID, net_busy=0: go to INJECT. inj_data=head, inj_enable=1, pop.
- IDLE, head dest != ROUTER_ID, net_busy=1: hold, inj_enable=0.
- INJECT (exactly one cycle): inj_count++ (wraps). Next state is GAP with counter=INJ_GAP, or IDLE if INJ_GAP=0. inj_enable returns to 0 unless IDLE immediately re-injects.
- GAP: inj_enable=0; decrement counter; go to IDLE when it reaches 1.
- inj_data holds its last value when not injecting.

Latency:
- Message pushed at edge N into an empty FIFO, net_busy=0: inj_enable is high during the cycle after edge N+1.
- Back-to-back injections are spaced 1+INJ_GAP cycles apart.

Eject slot (single register):
- Slot is draining when rx_valid && rx_ready.
- ej_valid with slot empty or draining: load ej_data, rx_valid=1.
- ej_valid with slot full and not draining: drop the packet, drop_count++ (saturating at 255).
- Router delivery has priority over loopback; loopback waits in the FIFO.
- Draining with no new packet: rx_valid=0.
- rx_data is the slot packet's payload bits [PACKET_SIZE-1:ROUTER_BITS].

Test Plan:
- Defaults, ROUTER_ID=0. Push dest=2 payload=6'h15 with net_busy=0 -> inj_enable high for exactly 1 cycle with inj_data=8'h56; inj_count=1.
- Push 4 messages to dest=1 back-to-back -> tx_ready=0 after the 4th push. Injections occur 2 cycles apart; the 5th offer is accepted only after the first pop.
- Hold net_busy=1 for 5 cycles with FIFO non-empty -> inj_enable stays 0 throughout. Injection occurs the cycle after net_busy drops.
- Push dest=0 payload=6'h3A -> no inj_enable; rx_valid=1 and rx_data=6'h3A on the 2nd cycle. With ej_valid=1 on that cycle, the router packet occupies the slot first and the loopback follows after the drain.
- rx_ready=0, three ej_valid pulses -> first captured; drop_count=2; rx_data equals the first packet's payload.
- Assert rst with FIFO holding 3 entries and the slot full -> next cycle tx_ready=1, rx_valid=0, both counters 0, and no injection follows.

Source files
------------

// File: rtl/ring_host_interface.sv
// Host-side network interface for one ring router: queues core messages, injects them
// into the ring (or loops self-addressed ones back), and buffers packets ejected to the core.
module ring_host_interface #(
  parameter int ROUTER_ID   = 0,
  parameter int PACKET_SIZE = 8,
  parameter int ROUTER_BITS = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int INJ_GAP     = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  input  logic [ROUTER_BITS-1:0]             tx_dest,
  input  logic [PACKET_SIZE-ROUTER_BITS-1:0] tx_payload,
  output logic [PACKET_SIZE-1:0]             inj_data,
  output logic                               inj_enable,
  input  logic                               net_busy,
  input  logic                               ej_valid,
  input  logic [PACKET_SIZE-1:0]             ej_data,
  output logic                               rx_valid,
  output logic [PACKET_SIZE-ROUTER_BITS-1:0] rx_data,
  input  logic                               rx_ready,
  output logic [7:0]                         inj_count,
  output logic [7:0]                         drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (INJ_GAP < 1) ? 1 : $clog2(INJ_GAP + 1);
  localparam logic [ROUTER_BITS-1:0] MY_ID    = ROUTER_BITS'(ROUTER_ID);
  localparam logic [GW-1:0]          GAP_LOAD = GW'(INJ_GAP);
  localparam logic [AW:0]            CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INJECT = 2'd1,
    GAP    = 2'd2
  } state_t;

  logic [PACKET_SIZE-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [AW:0]            fifo_cnt_r;
  logic                   push_s;
  logic                   pop_s;
  logic                   fifo_empty_s;
  logic [PACKET_SIZE-1:0] head_s;
  logic                   head_local_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [GW-1:0]          gap_cnt_r;
  logic [GW-1:0]          gap_cnt_nxt_s;
  logic                   decide_s;
  logic                   inj_load_s;
  logic                   loop_load_s;
  logic                   slot_open_s;
  logic                   slot_drain_s;
  logic                   unused_ej_dest_s;

  assign tx_ready     = (fifo_cnt_r != CNT_FULL);
  assign push_s       = tx_valid && tx_ready;
  assign pop_s        = inj_load_s || loop_load_s;
  assign fifo_empty_s = (fifo_cnt_r == {(AW + 1){1'b0}});
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign head_local_s = (head_s[ROUTER_BITS-1:0] == MY_ID);
  assign slot_drain_s = rx_valid && rx_ready;
  assign slot_open_s  = !rx_valid || rx_ready;
  // Ejected packets are always addressed to this router, so their dest field carries no information.
  assign unused_ej_dest_s = ^ej_data[ROUTER_BITS-1:0];

  // Queue storage; entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {tx_payload, tx_dest};
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fifo_cnt_r <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + (AW + 1)'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - (AW + 1)'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Injector next state: the head is considered in IDLE and also on the last cycle of the
  // gap (or the inject cycle when there is no gap), so injections land 1+INJ_GAP apart.
  always_comb begin
    state_nxt_s   = state_r;
    gap_cnt_nxt_s = gap_cnt_r;
    decide_s      = 1'b0;
    inj_load_s    = 1'b0;
    loop_load_s   = 1'b0;
    case (state_r)
      IDLE: decide_s = 1'b1;
      INJECT: begin
        if (INJ_GAP == 0) begin
          decide_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s   = GAP;
          gap_cnt_nxt_s = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt_r <= GW'(1)) begin
          decide_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r - GW'(1);
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    if (decide_s && !fifo_empty_s && head_local_s) begin
      loop_load_s = slot_open_s && !ej_valid;
    end else if (decide_s && !fifo_empty_s && !net_busy) begin
      inj_load_s  = 1'b1;
      state_nxt_s = INJECT;
    end else begin
      inj_load_s = 1'b0;
    end
  end

  // Injector state and registered injection outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      gap_cnt_r  <= {GW{1'b0}};
      inj_enable <= 1'b0;
      inj_data   <= {PACKET_SIZE{1'b0}};
      inj_count  <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      gap_cnt_r  <= gap_cnt_nxt_s;
      inj_enable <= inj_load_s;
      if (inj_load_s) inj_data <= head_s;
      if (state_r == INJECT) inj_count <= inj_count + 8'd1;
    end
  end

  // Eject slot: router delivery wins over loopback; a delivery into a stuck slot is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid   <= 1'b0;
      rx_data    <= {(PACKET_SIZE - ROUTER_BITS){1'b0}};
      drop_count <= 8'd0;
    end else if (ej_valid) begin
      if (slot_open_s) begin
        rx_valid <= 1'b1;
        rx_data  <= ej_data[PACKET_SIZE-1:ROUTER_BITS];
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end else begin
        drop_count <= drop_count;
      end
    end else if (loop_load_s) begin
      rx_valid <= 1'b1;
      rx_data  <= head_s[PACKET_SIZE-1:ROUTER_BITS];
    end else if (slot_drain_s) begin
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rx_valid;
    end
  end

endmodule

// File: tb/tb_ring_host_interface.sv
// Self-checking bench for ring_host_interface: vector table plus scoreboarded
// injection and eject streams, with hand sequences for timing corner cases.
module tb_ring_host_interface;

  logic       clk;
  logic       rst;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] tx_dest;
  logic [5:0] tx_payload;
  logic [7:0] inj_data;
  logic       inj_enable;
  logic       net_busy;
  logic       ej_valid;
  logic [7:0] ej_data;
  logic       rx_valid;
  logic [5:0] rx_data;
  logic       rx_ready;
  logic [7:0] inj_count;
  logic [7:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] inj_q[$];
  logic [5:0] rx_q[$];
  int         inj_cycles[$];
  logic [7:0] exp_inj;

  typedef struct packed {
    logic [1:0] dest;
    logic [5:0] payload;
    logic       loop;
    logic [7:0] exp_pkt;
    logic [5:0] exp_rx;
  } vec_t;

  vec_t vecs [6];

  ring_host_interface dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_dest   (tx_dest),
    .tx_payload(tx_payload),
    .inj_data  (inj_data),
    .inj_enable(inj_enable),
    .net_busy  (net_busy),
    .ej_valid  (ej_valid),
    .ej_data   (ej_data),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .inj_count (inj_count),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, between driving edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (inj_enable) begin
        inj_cycles.push_back(cyc);
        if (inj_q.size() == 0) check("inj_unexpected", 32'(inj_data), 32'hFFFF_FFFF);
        else check("inj_data", 32'(inj_data), 32'(inj_q.pop_front()));
      end
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
        else check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic [5:0] p);
    int w = 0;
    tx_valid   = 1'b1;
    tx_dest    = d;
    tx_payload = p;
    while (!tx_ready && w < 50) begin
      tick();
      w++;
    end
    check("send_ready", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((inj_q.size() != 0 || rx_q.size() != 0) && w < 200) begin
      tick();
      w++;
    end
    check("drain_pending", 32'(inj_q.size() + rx_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    int base;
    vecs[0] = '{2'd1, 6'h3F, 1'b0, 8'hFD, 6'h00};
    vecs[1] = '{2'd3, 6'h00, 1'b0, 8'h03, 6'h00};
    vecs[2] = '{2'd0, 6'h3A, 1'b1, 8'h00, 6'h3A};
    vecs[3] = '{2'd2, 6'h2A, 1'b0, 8'hAA, 6'h00};
    vecs[4] = '{2'd0, 6'h01, 1'b1, 8'h00, 6'h01};
    vecs[5] = '{2'd1, 6'h10, 1'b0, 8'h41, 6'h00};

    rst = 1'b1; tx_valid = 1'b0; tx_dest = 2'd0; tx_payload = 6'd0;
    net_busy = 1'b0; ej_valid = 1'b0; ej_data = 8'd0; rx_ready = 1'b0;
    exp_inj = 8'd0;
    tick(); tick();
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_inj_enable", 32'(inj_enable), 32'd0);
    check("rst_inj_data", 32'(inj_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_inj_count", 32'(inj_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    tick();

    // Latency: push at edge N, strobe during the cycle after edge N+1, one cycle wide.
    inj_q.push_back(8'h56);
    send(2'd2, 6'h15);
    check("lat_enable_n", 32'(inj_enable), 32'd0);
    tick();
    check("lat_enable_n1", 32'(inj_enable), 32'd1);
    check("lat_data", 32'(inj_data), 32'h56);
    tick();
    check("lat_enable_n2", 32'(inj_enable), 32'd0);
    check("lat_count", 32'(inj_count), 32'd1);
    check("lat_data_hold", 32'(inj_data), 32'h56);
    exp_inj = 8'd1;
    wait_drain();

    // Table: mixed remote and loopback messages, core always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].loop) rx_q.push_back(vecs[i].exp_rx);
      else begin
        inj_q.push_back(vecs[i].exp_pkt);
        exp_inj = exp_inj + 8'd1;
      end
      send(vecs[i].dest, vecs[i].payload);
      wait_drain();
      check("vec_inj_count", 32'(inj_count), 32'(exp_inj));
      check("vec_rx_valid", 32'(rx_valid), 32'd0);
    end
    rx_ready = 1'b0;

    // Fill under net_busy, hold, then release: backpressure and 1+INJ_GAP spacing.
    net_busy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      inj_q.push_back({6'(k), 2'd1});
      send(2'd1, 6'(k));
    end
    check("full_tx_ready", 32'(tx_ready), 32'd0);
    inj_q.push_back({6'd5, 2'd1});
    tx_valid = 1'b1; tx_dest = 2'd1; tx_payload = 6'd5;
    for (int k = 0; k < 5; k++) begin
      check("busy_enable", 32'(inj_enable), 32'd0);
      check("busy_tx_ready", 32'(tx_ready), 32'd0);
      tick();
    end
    base = inj_cycles.size();
    net_busy = 1'b0;
    tick();
    check("release_enable", 32'(inj_enable), 32'd1);
    check("release_data", 32'(inj_data), 32'h05);
    check("pop_tx_ready", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
    exp_inj = exp_inj + 8'd5;
    wait_drain();
    check("spacing_events", 32'(inj_cycles.size() - base), 32'd5);
    for (int k = 1; k < 5 && base + k < inj_cycles.size(); k++)
      check("spacing", 32'(inj_cycles[base + k] - inj_cycles[base + k - 1]), 32'd2);
    check("burst_count", 32'(inj_count), 32'(exp_inj));

    // Loopback timing: slot loads on the 2nd cycle after the push, never injects.
    base = inj_cycles.size();
    rx_q.push_back(6'h3A);
    send(2'd0, 6'h3A);
    check("loop_rx_valid_n", 32'(rx_valid), 32'd0);
    tick();
    check("loop_rx_valid", 32'(rx_valid), 32'd1);
    check("loop_rx_data", 32'(rx_data), 32'h3A);
    check("loop_no_inj", 32'(inj_cycles.size() - base), 32'd0);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    check("loop_drained", 32'(rx_valid), 32'd0);

    // Router delivery collides with a pending loopback: router first, loopback after drain.
    rx_q.push_back(6'h11);
    rx_q.push_back(6'h3A);
    send(2'd0, 6'h3A);
    ej_valid = 1'b1; ej_data = 8'h44;
    tick();
    ej_valid = 1'b0;
    check("coll_rx_valid", 32'(rx_valid), 32'd1);
    check("coll_rx_data", 32'(rx_data), 32'h11);
    tick();
    check("coll_hold_data", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    tick();
    check("coll_loop_valid", 32'(rx_valid), 32'd1);
    check("coll_loop_data", 32'(rx_data), 32'h3A);
    tick();
    rx_ready = 1'b0;
    check("coll_empty", 32'(rx_valid), 32'd0);
    check("coll_no_drop", 32'(drop_count), 32'd0);
    check("coll_sb_empty", 32'(rx_q.size()), 32'd0);

    // Drops while the core stalls, then saturation.
    rx_q.push_back(6'h30);
    ej_valid = 1'b1;
    ej_data = 8'hC1; tick();
    ej_data = 8'h22; tick();
    ej_data = 8'h73; tick();
    ej_valid = 1'b0;
    check("drop_rx_valid", 32'(rx_valid), 32'd1);
    check("drop_rx_data", 32'(rx_data), 32'h30);
    check("drop_count2", 32'(drop_count), 32'd2);
    ej_valid = 1'b1; ej_data = 8'h5D;
    repeat (260) tick();
    ej_valid = 1'b0;
    check("drop_saturate", 32'(drop_count), 32'd255);
    check("drop_keep_data", 32'(rx_data), 32'h30);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    check("drop_drained", 32'(rx_valid), 32'd0);

    // Reset mid-operation with three queued entries and a full slot.
    net_busy = 1'b1;
    send(2'd2, 6'h01);
    send(2'd2, 6'h02);
    send(2'd2, 6'h03);
    ej_valid = 1'b1; ej_data = 8'h10; tick();
    ej_valid = 1'b0;
    check("pre_rst_rx_valid", 32'(rx_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_inj_count", 32'(inj_count), 32'd0);
    check("mid_rst_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0; net_busy = 1'b0;
    exp_inj = 8'd0;
    base = inj_cycles.size();
    repeat (10) tick();
    check("post_rst_no_inj", 32'(inj_cycles.size() - base), 32'd0);
    check("post_rst_rx_valid", 32'(rx_valid), 32'd0);

    // inj_count wraps at 256.
    for (int i = 0; i < 255; i++) begin
      inj_q.push_back({6'(i), 2'd3});
      exp_inj = exp_inj + 8'd1;
      send(2'd3, 6'(i));
    end
    wait_drain();
    check("count_255", 32'(inj_count), 32'(exp_inj));
    inj_q.push_back({6'h2C, 2'd3});
    exp_inj = exp_inj + 8'd1;
    send(2'd3, 6'h2C);
    wait_drain();
    check("count_wrap", 32'(inj_count), 32'(exp_inj));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
